// File: rtl/arcade_input_cond.sv
// Per-player joystick conditioner: sync + debounce on every button, autofire on Fire,
// and Coin presses turned into fixed-width, rate-limited pulses through a small queue.

module arcade_input_cond_deb #(
  parameter int DEB_MS = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  input  logic tick,
  output logic stable
);
  localparam int CW = $clog2(DEB_MS + 1);
  localparam logic [CW-1:0] CLAST = CW'(DEB_MS - 1);

  logic          s1, s2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      // any cycle of agreement restarts the run, so only unbroken disagreement flips
      if (s2 == stable) cnt <= '0;
      else if (tick) begin
        if (cnt == CLAST) begin
          stable <= ~stable;
          cnt    <= '0;
        end else cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module arcade_input_cond #(
  parameter int TICK_DIV    = 24576,
  parameter int DEB_MS      = 5,
  parameter int AF_MS       = 33,
  parameter int COIN_MS     = 100,
  parameter int COIN_GAP_MS = 100,
  parameter int QMAX        = 15
) (
  input  logic       clk,
  input  logic       RESET_N,
  input  logic [8:0] joy_in,
  input  logic       autofire_en,
  output logic [8:0] joy_out,
  output logic       coin_busy,
  output logic [7:0] coin_total
);
  localparam int TW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int AW   = $clog2(AF_MS + 1);
  localparam int CMAX = (COIN_MS > COIN_GAP_MS) ? COIN_MS : COIN_GAP_MS;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int QW   = $clog2(QMAX + 1);

  localparam logic [TW-1:0] TLAST  = TW'(TICK_DIV - 1);
  localparam logic [AW-1:0] ALAST  = AW'(AF_MS - 1);
  localparam logic [CW-1:0] CPULSE = CW'(COIN_MS);
  localparam logic [CW-1:0] CGAP   = CW'(COIN_GAP_MS);
  localparam logic [CW-1:0] CONE   = CW'(1);
  localparam logic [QW-1:0] QLAST  = QW'(QMAX);

  typedef enum logic [1:0] {IDLE, PULSE, GAP} coin_state_t;

  logic [TW-1:0] tcnt;
  logic          tick;
  logic [8:0]    stable;
  logic [6:0]    pass;
  logic          af_out, arm_prev;
  logic [AW-1:0] af_cnt;
  coin_state_t   state;
  logic [CW-1:0] ccnt;
  logic [QW-1:0] queue;
  logic          coin_prev, coin_out, coin_rise, take;

  assign tick = (tcnt == TLAST);

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) tcnt <= '0;
    else          tcnt <= tick ? '0 : tcnt + 1'b1;
  end

  for (genvar i = 0; i < 9; i++) begin : g_bit
    arcade_input_cond_deb #(.DEB_MS(DEB_MS)) u_deb (
      .clk   (clk),
      .rst_n (RESET_N),
      .raw   (joy_in[i]),
      .tick  (tick),
      .stable(stable[i])
    );
  end

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) pass <= '0;
    else          pass <= {stable[8], stable[6:5], stable[3:0]};
  end

  // arm_prev low means this cycle starts a held (fire & enabled) period: restart high
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      af_out   <= 1'b0;
      af_cnt   <= '0;
      arm_prev <= 1'b0;
    end else begin
      arm_prev <= autofire_en & stable[4];
      if (!autofire_en) begin
        af_out <= stable[4];
        af_cnt <= '0;
      end else if (!stable[4]) begin
        af_out <= 1'b0;
        af_cnt <= '0;
      end else if (!arm_prev) begin
        af_out <= 1'b1;
        af_cnt <= '0;
      end else if (tick) begin
        if (af_cnt == ALAST) begin
          af_out <= ~af_out;
          af_cnt <= '0;
        end else af_cnt <= af_cnt + 1'b1;
      end
    end
  end

  assign coin_rise = stable[7] & ~coin_prev;
  assign take      = (state == IDLE) && (queue != '0);

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      coin_prev  <= 1'b0;
      queue      <= '0;
      state      <= IDLE;
      ccnt       <= '0;
      coin_out   <= 1'b0;
      coin_total <= '0;
    end else begin
      coin_prev <= stable[7];
      if (coin_rise && !take) begin
        if (queue != QLAST) queue <= queue + 1'b1;
      end else if (take && !coin_rise) queue <= queue - 1'b1;

      case (state)
        IDLE: if (take) begin
          state      <= PULSE;
          ccnt       <= CPULSE;
          coin_out   <= 1'b1;
          coin_total <= coin_total + 1'b1;
        end
        PULSE: if (tick) begin
          if (ccnt == CONE) begin
            state    <= GAP;
            ccnt     <= CGAP;
            coin_out <= 1'b0;
          end else ccnt <= ccnt - 1'b1;
        end
        GAP: if (tick) begin
          if (ccnt == CONE) begin
            state <= IDLE;
            ccnt  <= '0;
          end else ccnt <= ccnt - 1'b1;
        end
        default: begin
          state    <= IDLE;
          coin_out <= 1'b0;
        end
      endcase
    end
  end

  assign coin_busy = (state != IDLE) || (queue != '0);
  assign joy_out   = {pass[6], coin_out, pass[5:4], af_out, pass[3:0]};
endmodule

// File: tb/tb_arcade_input_cond.sv
// Scoreboard bench: inputs change only at tick boundaries, a tick-level model predicts
// every output, and a monitor compares once per tick interval.

module tb_arcade_input_cond;
  localparam int TICK_DIV = 4, DEB = 3, AF = 2, CMS = 5, CGAP = 3, QMAX = 15;

  logic       clk = 1'b0;
  logic       RESET_N = 1'b0;
  logic [8:0] joy_in = '0;
  logic       autofire_en = 1'b0;
  logic [8:0] joy_out;
  logic       coin_busy;
  logic [7:0] coin_total;

  arcade_input_cond #(
    .TICK_DIV(TICK_DIV), .DEB_MS(DEB), .AF_MS(AF),
    .COIN_MS(CMS), .COIN_GAP_MS(CGAP), .QMAX(QMAX)
  ) dut (
    .clk        (clk),
    .RESET_N    (RESET_N),
    .joy_in     (joy_in),
    .autofire_en(autofire_en),
    .joy_out    (joy_out),
    .coin_busy  (coin_busy),
    .coin_total (coin_total)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] joy;
    logic       busy;
    logic [7:0] total;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   ecnt = 0;   // posedges since reset release; edge 4k carries tick k

  always @(posedge clk) begin
    if (!RESET_N) ecnt <= 0;
    else          ecnt <= ecnt + 1;
  end

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (t=%0t)", nm, got, want, $time);
    end
  endtask

  // Monitor: tick k's outcome has settled by edge 4k+3
  always @(negedge clk) begin
    exp_t e;
    if (RESET_N && ecnt >= 7 && (ecnt % 4) == 3 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("joy_out", int'(joy_out), int'(e.joy));
      chk("coin_busy", int'(coin_busy), int'(e.busy));
      chk("coin_total", int'(coin_total), int'(e.total));
    end
  end

  // Reference model, one evaluation per 1 ms tick
  bit [8:0] m_st;
  int       m_dc[9];
  bit       m_held, m_af;
  int       m_ph, m_q, m_mode, m_rem, m_total;   // m_mode: 0 idle, 1 pulse, 2 gap
  logic [8:0] cur_in;

  task automatic model_init();
    m_st = '0; m_held = 0; m_af = 0; m_ph = 0;
    m_q = 0; m_mode = 0; m_rem = 0; m_total = 0;
    for (int b = 0; b < 9; b++) m_dc[b] = 0;
  endtask

  task automatic try_start();
    if (m_mode == 0 && m_q > 0) begin
      m_mode  = 1;
      m_rem   = CMS;
      m_q     = m_q - 1;
      m_total = (m_total + 1) % 256;
    end
  endtask

  task automatic model_tick(input logic [8:0] v, input logic en_new);
    exp_t e;
    bit   old_coin;
    if (m_held) begin
      m_ph++;
      if (m_ph == AF) begin m_af = ~m_af; m_ph = 0; end
    end
    if (m_mode == 1) begin
      m_rem--;
      if (m_rem == 0) begin m_mode = 2; m_rem = CGAP; end
    end else if (m_mode == 2) begin
      m_rem--;
      if (m_rem == 0) m_mode = 0;
    end
    old_coin = m_st[7];
    for (int b = 0; b < 9; b++) begin
      if (v[b] == m_st[b]) m_dc[b] = 0;
      else begin
        m_dc[b]++;
        if (m_dc[b] == DEB) begin m_st[b] = ~m_st[b]; m_dc[b] = 0; end
      end
    end
    if (!en_new)       m_af = m_st[4];
    else if (!m_st[4]) m_af = 0;
    else if (!m_held)  begin m_af = 1; m_ph = 0; end
    m_held = m_st[4] && en_new;
    try_start();
    if (m_st[7] && !old_coin) m_q = (m_q < QMAX) ? m_q + 1 : QMAX;
    try_start();
    e.joy   = {m_st[8], (m_mode == 1), m_st[6], m_st[5], m_af, m_st[3:0]};
    e.busy  = (m_mode != 0) || (m_q > 0);
    e.total = 8'(m_total);
    exp_q.push_back(e);
  endtask

  // Drive the next tick interval's inputs just after tick edge 4k, then model tick k
  task automatic step(input logic [8:0] nin, input logic nen);
    logic [8:0] v;
    do @(negedge clk); while (!(ecnt > 0 && (ecnt % 4) == 0));
    v = cur_in;
    joy_in = nin;
    autofire_en = nen;
    model_tick(v, nen);
    cur_in = nin;
  endtask

  initial begin
    logic [8:0] rin;
    logic       ren;
    int         rl[9];
    int         waited;

    // Reset with all buttons held
    model_init();
    joy_in = 9'h1FF; cur_in = 9'h1FF; autofire_en = 0; RESET_N = 0;
    repeat (3) @(negedge clk);
    chk("rst_joy_out", int'(joy_out), 0);
    chk("rst_coin_busy", int'(coin_busy), 0);
    chk("rst_coin_total", int'(coin_total), 0);
    RESET_N = 1;
    repeat (20) step(9'h1FF, 0);

    // Glitch rejection on bit 0
    repeat (6) step(9'h000, 0);
    repeat (2) step(9'h001, 0);
    repeat (4) step(9'h000, 0);
    repeat (3) step(9'h001, 0);
    repeat (3) step(9'h000, 0);
    repeat (4) step(9'h000, 0);

    // Autofire held for 20 ticks, then released
    repeat (2)  step(9'h000, 1);
    repeat (20) step(9'h010, 1);
    repeat (6)  step(9'h000, 1);

    // Coin burst of three debounced presses
    repeat (3) begin
      repeat (3) step(9'h080, 0);
      repeat (3) step(9'h000, 0);
    end
    repeat (40) step(9'h000, 0);

    // Queue saturation, then full drain
    repeat (70) begin
      repeat (3) step(9'h080, 0);
      repeat (3) step(9'h000, 0);
    end
    repeat (160) step(9'h000, 0);

    // Randomized run-length stimulus on every bit plus random autofire toggling
    rin = '0; ren = 0;
    for (int b = 0; b < 9; b++) rl[b] = $urandom_range(1, 7);
    repeat (300) begin
      for (int b = 0; b < 9; b++) begin
        if (rl[b] == 0) begin rin[b] = ~rin[b]; rl[b] = $urandom_range(1, 7); end
        rl[b]--;
      end
      if ($urandom_range(0, 15) == 0) ren = ~ren;
      step(rin, ren);
    end
    repeat (160) step(9'h000, 0);

    // Reset asserted in the middle of a coin pulse
    waited = 0;
    while (m_mode != 1 && waited < 20) begin
      step(9'h080, 0);
      waited++;
    end
    if (m_mode != 1) begin
      checks++; errors++;
      $display("FAIL coin_pulse_wait got no pulse expected pulse within 20 ticks");
    end
    repeat (2) step(9'h080, 0);
    chk("pre_rst_coin", int'(joy_out[7]), 1);
    RESET_N = 0;
    joy_in = '0; cur_in = '0; autofire_en = 0;
    #1;
    chk("mid_rst_joy_out", int'(joy_out), 0);
    chk("mid_rst_coin_busy", int'(coin_busy), 0);
    chk("mid_rst_coin_total", int'(coin_total), 0);
    model_init();
    exp_q.delete();
    repeat (3) @(negedge clk);
    RESET_N = 1;
    repeat (30) step(9'h000, 0);

    repeat (8) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
